// File: rtl/priority_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// priority_fifo_write_arbiter
//
// Shares the single write port of priority_fifo among NUM_REQ producers.
// Arbitration is strict priority between two classes and round-robin within
// the winning class. Each requester has an aging counter. A low-priority
// requester that keeps losing is promoted into the high class once its age
// reaches STARVE_LIMIT. The winning word is captured in a one-entry register
// stage that drives the FIFO write port. That stage holds while the FIFO is
// full.
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   asynchronous, active-low; clears all state
//   req_valid        in   [NUM_REQ]         requester i has a word pending
//   req_prio         in   [NUM_REQ]         requester i priority (1 = high)
//   req_data         in   [NUM_REQ*DATA_W]  requester i payload at [i*DATA_W +: DATA_W]
//   req_ready        out  [NUM_REQ]         one-hot grant (combinational)
//   fifo_full        in   FIFO full flag
//   fifo_write_en    out  staged word valid (FIFO write_en)
//   fifo_data_in     out  [DATA_W] staged payload
//   fifo_priority_in out  staged effective priority
//   grant_id         out  [clog2(NUM_REQ)] requester whose word is staged
//   promoted         out  staged word was admitted by aging
// -----------------------------------------------------------------------------
module priority_fifo_write_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 8,
  parameter  int STARVE_LIMIT = 12,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_prio,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_write_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      fifo_priority_in,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      promoted
);

  localparam int             AGE_W   = 8;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  // Output stage and arbitration state
  logic                 wen_q,  wen_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 prio_q, prio_d;
  logic [IDX_W-1:0]     id_q,   id_d;
  logic                 prom_q, prom_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [AGE_W-1:0]     age_q [NUM_REQ];
  logic [AGE_W-1:0]     age_d [NUM_REQ];

  // Arbitration signals
  logic                 stage_free;
  logic                 any_valid;
  logic                 grant;
  logic [NUM_REQ-1:0]   eff;
  logic [NUM_REQ-1:0]   hi_valid;
  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [DATA_W-1:0]    win_data;
  logic                 win_eff;
  logic                 win_prio;

  // Effective priority: own priority bit, or promoted by aging.
  always_comb begin
    eff = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eff[i] = req_prio[i] | (age_q[i] == AGE_MAX);
    end
  end

  // The stage can accept a new word if it is empty or is being drained this
  // edge. Keeping reset in the grant term forces req_ready low during reset.
  always_comb begin
    stage_free = !wen_q || !fifo_full;
    any_valid  = |req_valid;
    grant      = reset && stage_free && any_valid;
    hi_valid   = req_valid & eff;
    cand       = (|hi_valid) ? hi_valid : req_valid;
  end

  // Round-robin pick: first candidate at or after last_grant+1, wrapping.
  always_comb begin : pick_c
    int base;
    int idx;
    win_idx   = '0;
    win_found = 1'b0;
    base      = int'(last_q) + 1;
    if (base >= NUM_REQ) begin
      base = 0;
    end
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = base + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && cand[IDX_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  // One-hot grant and the winner's payload / priority attributes.
  always_comb begin
    onehot   = '0;
    win_data = '0;
    win_eff  = 1'b0;
    win_prio = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        onehot[i] = grant;
        win_data  = req_data[i*DATA_W +: DATA_W];
        win_eff   = eff[i];
        win_prio  = req_prio[i];
      end
    end
  end

  assign req_ready = onehot;

  // Stage next state: load on grant, otherwise empty out once drained.
  always_comb begin
    wen_d  = wen_q;
    data_d = data_q;
    prio_d = prio_q;
    id_d   = id_q;
    prom_d = prom_q;
    last_d = last_q;
    if (grant) begin
      wen_d  = 1'b1;
      data_d = win_data;
      prio_d = win_eff;
      id_d   = win_idx;
      prom_d = win_eff & ~win_prio;
      last_d = win_idx;
    end else if (stage_free) begin
      wen_d  = 1'b0;
    end
  end

  // Aging: only a valid low-priority requester that lost to another grant
  // ages. With no grant (idle or blocked by fifo_full) the age holds.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      age_d[i] = age_q[i];
      if (!req_valid[i] || req_prio[i] || onehot[i]) begin
        age_d[i] = '0;
      end else if (grant && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wen_q  <= 1'b0;
      data_q <= '0;
      prio_q <= 1'b0;
      id_q   <= '0;
      prom_q <= 1'b0;
      last_q <= IDX_W'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      wen_q  <= wen_d;
      data_q <= data_d;
      prio_q <= prio_d;
      id_q   <= id_d;
      prom_q <= prom_d;
      last_q <= last_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign fifo_write_en    = wen_q;
  assign fifo_data_in     = data_q;
  assign fifo_priority_in = prio_q;
  assign grant_id         = id_q;
  assign promoted         = prom_q;

endmodule

// File: tb/tb_priority_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for priority_fifo_write_arbiter (NUM_REQ=4, DATA_W=8,
// STARVE_LIMIT=3). A behavioural model tracks the stage, ages and last grant.
// Every cycle it predicts req_ready and the stage outputs, and a handful of
// literal expectations pin the directed scenarios.
// -----------------------------------------------------------------------------
module tb_priority_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SL = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_prio, req_ready;
  logic [N*DW-1:0]   req_data;
  logic              fifo_full, fifo_write_en, fifo_priority_in, promoted;
  logic [DW-1:0]     fifo_data_in;
  logic [IW-1:0]     grant_id;

  priority_fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_prio(req_prio),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .fifo_priority_in(fifo_priority_in), .grant_id(grant_id), .promoted(promoted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int m_wen, m_data, m_prio, m_id, m_prom, m_last, m_win;
  int m_age [N];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_wen = 0; m_data = 0; m_prio = 0; m_id = 0; m_prom = 0;
    m_last = N - 1; m_win = -1;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  function automatic int m_eff(input int i);
    return (req_prio[i] || m_age[i] == SL) ? 1 : 0;
  endfunction

  // Winner: nearest valid index after m_last among the best class, or -1.
  function automatic int m_pick();
    int any_hi, best, bestd, d;
    if (!reset) return -1;
    if (m_wen == 1 && fifo_full) return -1;
    any_hi = 0;
    for (int i = 0; i < N; i++) if (req_valid[i] && m_eff(i) == 1) any_hi = 1;
    best = -1; bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && (any_hi == 0 || m_eff(i) == 1)) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic m_update();
    int e;
    if (m_win >= 0) begin
      e      = m_eff(m_win);
      m_wen  = 1;
      m_data = int'(req_data[m_win*DW +: DW]);
      m_prio = e;
      m_id   = m_win;
      m_prom = (e == 1 && !req_prio[m_win]) ? 1 : 0;
      m_last = m_win;
    end else if (m_wen == 0 || !fifo_full) begin
      m_wen = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || req_prio[i] || i == m_win) m_age[i] = 0;
      else if (m_win >= 0 && m_age[i] < SL) m_age[i] = m_age[i] + 1;
    end
  endtask

  // Drive inputs on the falling edge, then compare everything to the model.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] p,
                       input logic [N*DW-1:0] d, input logic f);
    @(negedge clk);
    req_valid = v; req_prio = p; req_data = d; fifo_full = f;
    #1;
    m_win = m_pick();
    check("req_ready", int'(req_ready), (m_win < 0) ? 0 : (1 << m_win));
    check("write_en", int'(fifo_write_en), m_wen);
    check("data_in", int'(fifo_data_in), m_data);
    check("priority_in", int'(fifo_priority_in), m_prio);
    check("grant_id", int'(grant_id), m_id);
    check("promoted", int'(promoted), m_prom);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_update();
    #2;
  endtask

  function automatic logic [N*DW-1:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  logic [N-1:0]    rv, rp;
  logic [N*DW-1:0] rd;
  logic            rf;

  initial begin
    req_valid = '0; req_prio = '0; req_data = '0; fifo_full = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    m_reset();

    // Reset held with everyone requesting
    drive(4'hF, 4'h0, pk(8'h01, 8'h02, 8'h03, 8'h04), 1'b0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_wen", int'(fifo_write_en), 0);
    tick();
    reset = 1'b1;
    drive(4'hF, 4'h0, pk(8'h01, 8'h02, 8'h03, 8'h04), 1'b0);
    check("first_grant", int'(req_ready), 1);
    tick();

    // Single write
    drive(4'b0010, 4'b0000, pk(8'h00, 8'hAA, 8'h00, 8'h00), 1'b0);
    check("single_ready", int'(req_ready), 2);
    tick();
    drive(4'b0000, 4'b0000, '0, 1'b0);
    check("single_wen", int'(fifo_write_en), 1);
    check("single_data", int'(fifo_data_in), 8'hAA);
    check("single_prio", int'(fifo_priority_in), 0);
    check("single_id", int'(grant_id), 1);
    check("single_prom", int'(promoted), 0);
    tick();

    // Class priority
    drive(4'b0101, 4'b0100, pk(8'hAA, 8'h00, 8'hBB, 8'h00), 1'b0);
    check("class_ready1", int'(req_ready), 4);
    tick();
    drive(4'b0001, 4'b0000, pk(8'hAA, 8'h00, 8'h00, 8'h00), 1'b0);
    check("class_ready2", int'(req_ready), 1);
    check("class_data1", int'(fifo_data_in), 8'hBB);
    check("class_prio1", int'(fifo_priority_in), 1);
    tick();
    drive(4'b0000, 4'b0000, '0, 1'b0);
    check("class_data2", int'(fifo_data_in), 8'hAA);
    check("class_prio2", int'(fifo_priority_in), 0);
    tick();

    // Round-robin from a fresh reset
    @(negedge clk); reset = 1'b0; #1 m_reset();
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(4'hF, 4'hF, pk(8'h10, 8'h11, 8'h12, 8'h13), 1'b0);
      check("rr_ready", int'(req_ready), 1 << (k % 4));
      if (k > 0) check("rr_data", int'(fifo_data_in), 8'h10 + ((k - 1) % 4));
      tick();
    end

    // Backpressure
    drive(4'b0100, 4'b0000, pk(8'h00, 8'h00, 8'hCC, 8'h00), 1'b0);
    check("bp_ready0", int'(req_ready), 4);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0011, 4'b0000, pk(8'h01, 8'h02, 8'h00, 8'h00), 1'b1);
      check("bp_ready", int'(req_ready), 0);
      check("bp_wen", int'(fifo_write_en), 1);
      check("bp_data", int'(fifo_data_in), 8'hCC);
      tick();
    end
    drive(4'b0011, 4'b0000, pk(8'h01, 8'h02, 8'h00, 8'h00), 1'b0);
    check("bp_release", int'(req_ready), 1);
    tick();
    drive(4'b0010, 4'b0000, pk(8'h00, 8'h02, 8'h00, 8'h00), 1'b0);
    check("bp_next_data", int'(fifo_data_in), 8'h01);
    tick();

    // Starvation with STARVE_LIMIT=3
    for (int k = 0; k < 4; k++) begin
      drive(4'b1010, 4'b0010, pk(8'h00, 8'h55, 8'h00, 8'hDD), 1'b0);
      check("starve_ready", int'(req_ready), (k < 3) ? 2 : 8);
      tick();
    end
    drive(4'b1010, 4'b0010, pk(8'h00, 8'h55, 8'h00, 8'hDE), 1'b0);
    check("starve_ready_after", int'(req_ready), 2);
    check("starve_data", int'(fifo_data_in), 8'hDD);
    check("starve_prio", int'(fifo_priority_in), 1);
    check("starve_prom", int'(promoted), 1);
    check("starve_id", int'(grant_id), 3);
    tick();

    // Asynchronous reset mid-operation
    drive(4'b0100, 4'b0000, pk(8'h00, 8'h00, 8'h77, 8'h00), 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("async_wen", int'(fifo_write_en), 0);
    check("async_data", int'(fifo_data_in), 0);
    check("async_id", int'(grant_id), 0);
    check("async_ready", int'(req_ready), 0);
    m_reset();
    drive(4'hF, 4'h0, pk(8'h01, 8'h02, 8'h03, 8'h04), 1'b0);
    tick();
    reset = 1'b1;

    // Randomized traffic; pending words are held until granted
    rv = '0; rp = '0; rd = '0; m_win = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rv[i] && m_win != i) begin
          if ($urandom_range(19) == 0) rv[i] = 1'b0;
        end else begin
          rv[i] = ($urandom_range(9) < 6);
          rp[i] = ($urandom_range(9) < 4);
          rd[i*DW +: DW] = DW'($urandom);
        end
      end
      rf = ($urandom_range(3) == 0);
      drive(rv, rp, rd, rf);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
